// File: rtl/dmem_sequencer.sv
// Purpose: load DEPTH activations into the data memory, then replay the memory PASSES times to the MAC array.
// Latency: mem_rdaddr to out_data is 1 cycle; 1 element/cycle while out_ready stays high.
// Backpressure: load is stalled by in_valid; out_valid & !out_ready freezes out_* and suppresses reads.
// Optional: define DMEM_SEQ_TERNARY_CHECK_EN to remap -2 loads to -1 and raise a sticky err.
module dmem_sequencer #(
   parameter int DEPTH  = 256,
   parameter int AW     = 9,
   parameter int DW     = 2,
   parameter int PASSES = 10,
   parameter int PW     = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_wraddr,
   output logic [DW-1:0] mem_wrdata,
   output logic          mem_rd,
   output logic [AW-1:0] mem_rdaddr,
   input  logic [DW-1:0] mem_rddata,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic [PW-1:0] out_pass,
   output logic          busy,
   output logic          done,
   output logic          err
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] wr_cnt;
   logic [AW-1:0] rd_cnt;
   logic [PW-1:0] pass_cnt;
   logic          issue;
   logic          wr_last;
   logic          rd_last;
   logic          pass_last;

`ifdef DMEM_SEQ_TERNARY_CHECK_EN
   localparam logic [DW-1:0] ILLEGAL = {1'b1, {(DW-1){1'b0}}};
`endif

   assign wr_last    = (wr_cnt == AW'(DEPTH-1));
   assign rd_last    = (rd_cnt == AW'(DEPTH-1));
   assign pass_last  = (pass_cnt == PW'(PASSES-1));
   assign mem_wraddr = wr_cnt;
   assign mem_rdaddr = rd_cnt;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: one trip IDLE -> LOAD -> STREAM -> DRAIN -> IDLE per image
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start) state_d = S_LOAD;
         S_LOAD:   if (mem_we && wr_last) state_d = S_STREAM;
         S_STREAM: if (issue && rd_last && pass_last) state_d = S_DRAIN;
         S_DRAIN:  if (out_ready) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Output logic: handshakes, memory strobes and the read-issue condition
   always_comb begin
      in_ready   = (state_q == S_LOAD);
      mem_we     = in_valid & in_ready;
      issue      = (state_q == S_STREAM) & (~out_valid | out_ready);
      mem_rd     = issue;
      busy       = (state_q != S_IDLE);
      mem_wrdata = '0;
      if (mem_we) begin
`ifdef DMEM_SEQ_TERNARY_CHECK_EN
         mem_wrdata = (in_data == ILLEGAL) ? '1 : in_data;
`else
         mem_wrdata = in_data;
`endif
      end
   end

   // Counters and the registered replay stage
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         pass_cnt  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_pass  <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) wr_cnt <= '0;
            end
            S_LOAD: begin
               if (mem_we) begin
                  wr_cnt <= wr_cnt + AW'(1);
                  if (wr_last) begin
                     rd_cnt   <= '0;
                     pass_cnt <= '0;
                  end
               end
            end
            S_STREAM: begin
               if (issue) begin
                  out_data  <= mem_rddata;
                  out_valid <= 1'b1;
                  out_last  <= rd_last;
                  out_pass  <= pass_cnt;
                  if (rd_last) begin
                     rd_cnt   <= '0;
                     pass_cnt <= pass_cnt + PW'(1);
                  end else begin
                     rd_cnt <= rd_cnt + AW'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  done      <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef DMEM_SEQ_TERNARY_CHECK_EN
   // Sticky flag for a -2 load; a fresh image (accepted start) clears it
   always_ff @(posedge clk) begin
      if (rst)                             err <= 1'b0;
      else if (state_q == S_IDLE && start) err <= 1'b0;
      else if (mem_we && in_data == ILLEGAL) err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

endmodule
